// File: rtl/press_classifier_pkg.sv
// Shared types and defaults for the button press classifier.
// Holds the FSM state encoding and the default hold / gap lengths.
package press_classifier_pkg;

  localparam int LONG_COUNT_DEF = 8;
  localparam int GAP_COUNT_DEF  = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_GAP    = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_HELD   = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/press_classifier_timer.sv
// Cycle timer for the press classifier: synchronous clear has priority
// over count enable; the count holds when neither is asserted.
module press_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button activity into short, long and double presses.
// state     | meaning
// IDLE      | waiting for a press
// PRESS1    | first press held, timing toward long press
// GAP       | released after a short press, waiting for a second press
// PRESS2    | second press held
// HELD      | long (or long second) press reported, waiting for release
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int LONG_COUNT = LONG_COUNT_DEF,
  parameter int GAP_COUNT  = GAP_COUNT_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic level,
  input  logic rise,
  input  logic fall,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  localparam int TW = $clog2(max_int(LONG_COUNT, GAP_COUNT) + 1);
  localparam logic [TW-1:0] LONG_LIM = TW'(LONG_COUNT - 1);
  localparam logic [TW-1:0] GAP_LIM  = TW'(GAP_COUNT - 1);

  state_e        state_q, state_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          double_q, double_d;
  logic          busy_q, busy_d;
  logic          timer_clear, timer_enable;
  logic [TW-1:0] timer;
  logic          rise_v, fall_v;

  // Simultaneous edges cancel; a rise is only trusted with the level high.
  assign rise_v = rise & level & ~fall;
  assign fall_v = fall & ~rise;

  press_timer #(.W(TW)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .count   (timer)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rise_v) state_d = ST_PRESS1;
      ST_PRESS1: begin
        if (fall_v)                 state_d = ST_GAP;
        else if (timer == LONG_LIM) state_d = ST_HELD;
      end
      ST_GAP: begin
        if (rise_v)                state_d = ST_PRESS2;
        else if (timer == GAP_LIM) state_d = ST_IDLE;
      end
      ST_PRESS2: begin
        if (fall_v)                 state_d = ST_IDLE;
        else if (timer == LONG_LIM) state_d = ST_HELD;
      end
      ST_HELD:   if (fall_v) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    short_d      = (state_q == ST_GAP) && !rise_v && (timer == GAP_LIM);
    long_d       = (state_q == ST_PRESS1) && !fall_v && (timer == LONG_LIM);
    double_d     = (state_q == ST_PRESS2) && (fall_v || (timer == LONG_LIM));
    busy_d       = (state_d != ST_IDLE);
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    // The timer rests at zero in IDLE; the sampled rise counts as the first
    // held cycle so a long press lands LONG_COUNT cycles after the rise.
    if (state_q == ST_IDLE) begin
      timer_clear  = !rise_v;
      timer_enable = rise_v;
    end else if (state_d != state_q) begin
      timer_clear  = 1'b1;
    end else if (state_q != ST_HELD) begin
      timer_enable = 1'b1;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign busy         = busy_q;

endmodule

// File: doc/press_classifier.md
PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 SHALL have parameter LONG_COUNT, default 8, meaning cycles a press must be held to count as long (>=2).
REQ-002 SHALL have parameter GAP_COUNT, default 6, meaning the maximum release gap, in cycles, that still forms a double press (>=2).
REQ-003 SHALL have port clock  input  1  meaning the single rising-edge clock for all state.
REQ-004 SHALL have port reset_n  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port level  input  1  meaning the debounced button level from the debounce stage.
REQ-006 SHALL have port rise  input  1  meaning the one-cycle rising-edge pulse from the debounce stage.
REQ-007 SHALL have port fall  input  1  meaning the one-cycle falling-edge pulse from the debounce stage.
REQ-008 SHALL have port short_press  output  1  meaning a one-cycle pulse for a single short press.
REQ-009 SHALL have port long_press  output  1  meaning a one-cycle pulse for a long press.
REQ-010 SHALL have port double_press  output  1  meaning a one-cycle pulse for two short presses within the gap.
REQ-011 SHALL have port busy  output  1  meaning the FSM is not in IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, PRESS1, GAP, PRESS2, HELD, with a timer that clears on every state change and increments otherwise.
REQ-013 IDLE: rise -> PRESS1; all other inputs ignored.
REQ-014 PRESS1: fall -> GAP; else timer == LONG_COUNT-1 -> assert long_press, go to HELD.
REQ-015 GAP: rise -> PRESS2; else timer == GAP_COUNT-1 -> assert short_press, go to IDLE.
REQ-016 PRESS2: fall -> assert double_press, go to IDLE; else timer == LONG_COUNT-1 -> assert double_press (no long_press), go to HELD.
REQ-017 HELD: fall -> IDLE; no pulses are generated in HELD.
REQ-018 All outputs SHALL be registered; each pulse is high exactly one cycle, in the cycle after the decisive edge or timeout.
REQ-019 At most one of short_press/long_press/double_press SHALL be high in any cycle.
REQ-020 long_press SHALL assert exactly LONG_COUNT cycles after the cycle in which rise was sampled, if no fall occurs in between.
REQ-021 If fall and a timeout coincide in the same cycle, fall SHALL win (PRESS1 -> GAP, PRESS2 -> double_press).
REQ-022 If rise and the GAP timeout coincide, rise SHALL win (-> PRESS2, no short_press).
REQ-023 If rise and fall are both high in one cycle, both SHALL be ignored.
REQ-024 The timer SHALL be $clog2(max(LONG_COUNT,GAP_COUNT)+1) bits wide and SHALL never wrap: every counting state exits at its limit.
REQ-025 busy SHALL equal (state != IDLE) and be registered with the state.

Reset
REQ-026 On reset_n low, the block SHALL go to IDLE immediately, clear the timer, and drive all outputs 0, regardless of the clock.
REQ-027 Reset asserted mid-press SHALL discard the pending classification; after release a new rise is needed, and a still-high level SHALL NOT start a press.

Structure
REQ-028 Package press_classifier_pkg SHALL hold the state enum and the default LONG_COUNT/GAP_COUNT constants.
REQ-029 The timer SHALL be one sub-module, press_timer (clear, enable, count output); all else stays in press_classifier.

Verification (LONG_COUNT=8, GAP_COUNT=6)
REQ-030 Rise at cycle 10, fall at cycle 13, no further rise -> short_press high only at cycle 20, busy low from cycle 20.
REQ-031 Rise at cycle 10, held -> long_press high only at cycle 18; fall at cycle 30 -> no pulse, busy low at 31.
REQ-032 Rise 10, fall 12, rise 15, fall 17 -> double_press high only at cycle 18, no short_press.
REQ-033 Rise 10, fall 12, rise at the GAP timeout cycle (18) -> no short_press; fall 20 -> double_press at 21.
REQ-034 Rise 10, reset_n low at cycle 14 (async, mid-cycle) -> outputs and busy 0 at once; level high after reset -> no pulse until a new rise.
